// File: rtl/spi_burst_reader.sv
// SPI mode-0 master that repeatedly burst-reads NUM_BYTES consecutive sensor registers.
// Every output is a register; all timing is derived from clk through the divider counter.
module spi_burst_reader #(
   parameter int         CLK_DIV     = 4,
   parameter int         NUM_BYTES   = 4,
   parameter logic [7:0] READ_CMD    = 8'h0B,
   parameter logic [7:0] START_ADDR  = 8'h10,
   parameter int         IDLE_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   MISO,
   output logic                   MOSI,
   output logic                   SCLK,
   output logic                   CS,
   output logic [NUM_BYTES*8-1:0] data_out,
   output logic                   data_valid,
   output logic                   busy
);
   localparam int NBITS = 16 + 8*NUM_BYTES;
   localparam int BW    = $clog2(NBITS+1);
   localparam int DW    = $clog2(CLK_DIV+1);
   localparam int GW    = $clog2(IDLE_CYCLES+1);
   localparam int DBITS = NUM_BYTES*8;

   localparam logic [BW-1:0] NBITS_C   = BW'(NBITS);
   localparam logic [BW-1:0] HDR_BITS  = BW'(16);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV-1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(IDLE_CYCLES-1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t           state_reg, state_next;
   logic [DW-1:0]    div_cnt_reg, div_cnt_next;
   logic [GW-1:0]    gap_cnt_reg, gap_cnt_next;
   logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
   logic [15:0]      tx_reg, tx_next;
   logic [DBITS-1:0] rx_reg, rx_next, rx_ordered;
   logic [DBITS-1:0] data_out_reg, data_out_next;
   logic             sclk_reg, sclk_next;
   logic             cs_reg, cs_next;
   logic             mosi_reg, mosi_next;
   logic             valid_reg, valid_next;
   logic             busy_reg, busy_next;
   logic             div_tick, gap_tick, active_next, start_burst;

   assign div_tick    = (div_cnt_reg == DIV_LAST);
   assign gap_tick    = (gap_cnt_reg == GAP_LAST);
   assign active_next = (state_next == SETUP) || (state_next == SHIFT) || (state_next == HOLD);
   assign start_burst = (state_next == SETUP) && ((state_reg == IDLE) || (state_reg == GAP));

   // Bytes arrive first-to-last at the top of rx_reg; the first one belongs in byte 0.
   generate
      for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_order
         assign rx_ordered[8*gi +: 8] = rx_reg[8*(NUM_BYTES-1-gi) +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         div_cnt_reg  <= '0;
         gap_cnt_reg  <= '0;
         bit_cnt_reg  <= '0;
         tx_reg       <= '0;
         rx_reg       <= '0;
         data_out_reg <= '0;
         sclk_reg     <= 1'b0;
         cs_reg       <= 1'b1;
         mosi_reg     <= 1'b0;
         valid_reg    <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         div_cnt_reg  <= div_cnt_next;
         gap_cnt_reg  <= gap_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         tx_reg       <= tx_next;
         rx_reg       <= rx_next;
         data_out_reg <= data_out_next;
         sclk_reg     <= sclk_next;
         cs_reg       <= cs_next;
         mosi_reg     <= mosi_next;
         valid_reg    <= valid_next;
         busy_reg     <= busy_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (enable) state_next = SETUP;
         SETUP:   if (div_tick) state_next = SHIFT;
         SHIFT:   if (div_tick && sclk_reg && (bit_cnt_reg == NBITS_C)) state_next = HOLD;
         HOLD:    if (div_tick) state_next = GAP;
         GAP:     if (gap_tick) state_next = enable ? SETUP : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      div_cnt_next  = '0;
      gap_cnt_next  = '0;
      bit_cnt_next  = bit_cnt_reg;
      tx_next       = tx_reg;
      rx_next       = rx_reg;
      data_out_next = data_out_reg;
      sclk_next     = 1'b0;
      valid_next    = 1'b0;
      case (state_reg)
         SETUP: div_cnt_next = div_tick ? '0 : div_cnt_reg + DW'(1);
         SHIFT: begin
            div_cnt_next = div_tick ? '0 : div_cnt_reg + DW'(1);
            sclk_next    = sclk_reg ^ div_tick;
            if (div_tick && !sclk_reg) begin
               bit_cnt_next = bit_cnt_reg + BW'(1);
               // The command/address phase clocks in don't-care bits.
               if (bit_cnt_reg >= HDR_BITS) rx_next = {rx_reg[DBITS-2:0], MISO};
            end
            if (div_tick && sclk_reg) tx_next = {tx_reg[14:0], 1'b0};
         end
         HOLD: begin
            div_cnt_next = div_tick ? '0 : div_cnt_reg + DW'(1);
            if (div_tick) begin
               data_out_next = rx_ordered;
               valid_next    = 1'b1;
            end
         end
         GAP:     gap_cnt_next = gap_cnt_reg + GW'(1);
         default: ;
      endcase
      if (start_burst) begin
         bit_cnt_next = '0;
         tx_next      = {READ_CMD, START_ADDR};
         rx_next      = '0;
      end
   end

   always_comb begin
      cs_next   = ~active_next;
      mosi_next = active_next ? tx_next[15] : 1'b0;
      busy_next = (state_next != IDLE);
   end

   assign MOSI       = mosi_reg;
   assign SCLK       = sclk_reg;
   assign CS         = cs_reg;
   assign data_out   = data_out_reg;
   assign data_valid = valid_reg;
   assign busy       = busy_reg;
endmodule
